inv_shiftrows_pipe: RTL
=======================

INV_SHIFTROWS_PIPE -- requirements
Module: inv_shiftrows_pipe

Interface
REQ-001 The block SHALL have parameter SHARES, default 5, giving the number of Boolean shares of the 64-bit PRINCE state.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a state.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a state this cycle.
REQ-006 The block SHALL have port in_inv, input, 1 bit: 1 selects inverse ShiftRows, 0 selects forward ShiftRows.
REQ-007 The block SHALL have port in_shares, input, 64*SHARES bits: share s occupies bits [64s+63:64s].
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_shares holds a valid state.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the state.
REQ-010 The block SHALL have port out_shares, output, 64*SHARES bits, with the same share layout as in_shares.

Function
REQ-011 The block SHALL index nibble n of a share as bits [4n+3:4n].
REQ-012 Inverse mode SHALL set out nibble 0..15 to in nibble 12,9,6,3,0,13,10,7,4,1,14,11,8,5,2,15 respectively.
REQ-013 Forward mode SHALL set out nibble 0..15 to in nibble 4,9,14,3,8,13,2,7,12,1,6,11,0,5,10,15 respectively.
REQ-014 The block SHALL apply the same permutation to every share independently, with no logic combining bits of different shares.
REQ-015 A transfer SHALL occur on each edge where in_valid and in_ready are both 1; the block SHALL latch in_inv together with in_shares.
REQ-016 The block SHALL present a state accepted while the output register is empty or draining on out_shares with out_valid=1 exactly one cycle later.
REQ-017 Storage SHALL be a two-entry skid buffer: a main output register plus one skid register; the permutation SHALL be applied before the registers.
REQ-018 in_ready SHALL be a register output equal to NOT skid_valid, with no combinational path from out_ready.
REQ-019 On an accept with main full and out_ready=0, the block SHALL write the state to the skid register, so in_ready falls the next cycle.
REQ-020 On an edge with out_ready=1 and skid full, the skid register SHALL move to main, and skid SHALL become empty unless an accept occurs in the same cycle.
REQ-021 An output handshake and an input accept on the same edge SHALL sustain throughput of one state per cycle with no bubble.
REQ-022 out_shares and the skid contents SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 States SHALL leave in acceptance order, and no state SHALL be dropped or duplicated.

Reset
REQ-024 While rst_n=0, the block SHALL clear out_valid and skid_valid, which drives in_ready to 1 and out_valid to 0.
REQ-025 While rst_n=0, the block SHALL clear out_shares and the skid data to all zeros, to avoid residual share leakage.
REQ-026 Reset asserted mid-operation SHALL discard all buffered states, and the first accept after release SHALL appear one cycle later.
REQ-027 The block SHALL ignore in_valid while rst_n=0.

Structure
REQ-028 Package prince_pkg SHALL hold STATE_W=64, NIBBLES=16, and the forward and inverse nibble permutation tables as constant arrays.
REQ-029 Combinational sub-module sr_perm (inputs: one 64-bit share and the inv bit; output: one 64-bit share) SHALL be instantiated SHARES times.

Verification
REQ-030 Scenario: share0=64'h0123456789ABCDEF, other shares 0, in_inv=1, out_ready=1 -> next cycle share0=64'h0DA741EB852FC963 and other shares 0.
REQ-031 Scenario: same input with in_inv=0 -> share0=64'h05AF49E38D27C16B; feeding that back with in_inv=1 -> 64'h0123456789ABCDEF.
REQ-032 Scenario: out_ready=0 while three states are offered -> two states accepted, in_ready=0 from the cycle after the second, out_shares stable; raising out_ready drains both in order.
REQ-033 Scenario: 100 back-to-back states with out_ready=1 -> 100 outputs on consecutive cycles, each equal to the reference permutation.
REQ-034 Scenario: rst_n pulsed low with both entries full -> out_valid=0, in_ready=1, and data registers zero during reset.
REQ-035 Scenario: random shares with SHARES=5 -> the XOR of the output shares equals the permutation of the XOR of the input shares.

Source files
------------

// File: rtl/prince_pkg.sv
// prince_pkg: constants shared by the PRINCE ShiftRows pipeline stage.
//   STATE_W  - width of one share of the PRINCE state
//   NIBBLES  - number of 4-bit nibbles per share
//   FWD_PERM - forward ShiftRows: out nibble n takes in nibble FWD_PERM[n]
//   INV_PERM - inverse ShiftRows: out nibble n takes in nibble INV_PERM[n]
package prince_pkg;

  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;

  localparam logic [3:0] FWD_PERM [NIBBLES] = '{
    4'd4, 4'd9, 4'd14, 4'd3, 4'd8, 4'd13, 4'd2, 4'd7,
    4'd12, 4'd1, 4'd6, 4'd11, 4'd0, 4'd5, 4'd10, 4'd15
  };

  localparam logic [3:0] INV_PERM [NIBBLES] = '{
    4'd12, 4'd9, 4'd6, 4'd3, 4'd0, 4'd13, 4'd10, 4'd7,
    4'd4, 4'd1, 4'd14, 4'd11, 4'd8, 4'd5, 4'd2, 4'd15
  };

endpackage

// File: rtl/sr_perm.sv
// sr_perm: combinational ShiftRows nibble permutation of a single share.
//   din  - one 64-bit share, nibble n at bits [4n+3:4n]
//   inv  - 1 = inverse ShiftRows, 0 = forward ShiftRows
//   dout - permuted share
module sr_perm
  import prince_pkg::*;
(
  input  logic [STATE_W-1:0] din,
  input  logic               inv,
  output logic [STATE_W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      logic [3:0] src;
      src = inv ? INV_PERM[n] : FWD_PERM[n];
      // Source nibble index times four gives the bit offset.
      dout[n*4 +: 4] = din[{src, 2'b00} +: 4];
    end
  end

endmodule

// File: rtl/inv_shiftrows_pipe.sv
// inv_shiftrows_pipe: masked (SHARES-way Boolean shared) PRINCE ShiftRows stage
// with a two-entry skid buffer on a valid/ready interface.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - upstream handshake; in_ready is a pure register output
//   in_inv                - 1 = inverse ShiftRows, 0 = forward
//   in_shares             - SHARES x 64-bit shares, share s at [64s+63:64s]
//   out_valid/out_ready   - downstream handshake
//   out_shares            - permuted shares, same layout
module inv_shiftrows_pipe
  import prince_pkg::*;
#(
  parameter int SHARES = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_inv,
  input  logic [STATE_W*SHARES-1:0]  in_shares,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [STATE_W*SHARES-1:0]  out_shares
);

  logic [STATE_W*SHARES-1:0] perm_data;

  // Each share is permuted by its own instance so no logic ever mixes shares.
  for (genvar s = 0; s < SHARES; s++) begin : g_share
    sr_perm u_perm (
      .din  (in_shares[s*STATE_W +: STATE_W]),
      .inv  (in_inv),
      .dout (perm_data[s*STATE_W +: STATE_W])
    );
  end

  logic                      out_valid_q, out_valid_d;
  logic [STATE_W*SHARES-1:0] out_data_q,  out_data_d;
  logic                      skid_valid_q, skid_valid_d;
  logic [STATE_W*SHARES-1:0] skid_data_q, skid_data_d;
  logic                      accept;

  assign in_ready   = ~skid_valid_q;
  assign accept     = in_valid & ~skid_valid_q;
  assign out_valid  = out_valid_q;
  assign out_shares = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      // Main register is empty or draining this edge: refill it, skid first
      // so acceptance order is preserved.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) skid_data_d = perm_data;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = perm_data;
      end
    end else if (accept) begin
      // Main is stalled: park the new state in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = perm_data;
    end
  end

  // Data registers are also cleared on reset so no share residue survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule
